// File: rtl/i8mac_seq_pkg.sv
// Shared types and defaults for the i8mac lane sequencer.
package i8mac_seq_pkg;

   // Default widths of the tap and output counts/indices.
   localparam int TAPW_DEF   = 16;
   localparam int OUTW_DEF   = 12;
   // Longest wait in DRAIN for the MAC result before flagging err.
   localparam int DRNMAX_DEF = 15;

   // One output point walks CLEAR -> ACC -> BIAS -> DRAIN, then loops or finishes.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_ACC   = 3'd2,
      ST_BIAS  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } seq_st_t;

   // Bits needed to hold the values 0..maxval (at least one bit).
   function automatic int cnt_width(input int maxval);
      int w;
      w = $clog2(maxval + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/i8mac_seq_cnt.sv
// Loadable up-counter with a terminal flag. Counting stops at term_val,
// so an index can never wrap past its last legal value.
module i8mac_seq_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         xreset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   input  logic [W-1:0] term_val,
   output logic [W-1:0] cnt,
   output logic         term
);

   assign term = (cnt == term_val);

   // Counter register: load wins over increment; increment saturates at term_val.
   always_ff @(posedge clk or posedge xreset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (xreset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (inc && !term) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/i8mac_seq.sv
// Sequencer for one i8mac lane: runs num_out output points of num_tap taps
// each, driving acl/aen/ivalid per point and tagging MAC results with the
// output index they belong to.
module i8mac_seq
   import i8mac_seq_pkg::*;
#(
   parameter int TAPW   = TAPW_DEF,
   parameter int OUTW   = OUTW_DEF,
   parameter int DRNMAX = DRNMAX_DEF
) (
   input  logic            clk,
   input  logic            xreset,
   input  logic            start,
   input  logic            abort,
   input  logic [TAPW-1:0] num_tap,
   input  logic [OUTW-1:0] num_out,
   input  logic            rdy,
   input  logic            tap_ok,
   input  logic            mac_acvalid,
   output logic            acl,
   output logic            aen,
   output logic            ivalid,
   output logic [TAPW-1:0] tap_idx,
   output logic [OUTW-1:0] out_idx,
   output logic            res_valid,
   output logic [OUTW-1:0] res_idx,
   output logic            busy,
   output logic            done,
   output logic            err
);

   localparam int WDW = cnt_width(DRNMAX);

   seq_st_t         state;
   seq_st_t         state_nx;

   // Run parameters, frozen for the whole run at the accepted start.
   logic [TAPW-1:0] num_tap_q;
   logic [OUTW-1:0] num_out_q;
   logic [TAPW-1:0] tap_last;
   logic [OUTW-1:0] out_last;
   logic            err_q;

   // Control strobes from the next-state logic.
   logic            accept;
   logic            err_set;
   logic            tap_load;
   logic            tap_inc;
   logic            tap_term;
   logic            out_load;
   logic            out_inc;
   logic            out_term;
   logic            wd_load;
   logic            wd_inc;
   logic            wd_term;
   logic [WDW-1:0]  wdog;

   // Last legal index of each count; only consulted once the counts are non-zero.
   assign tap_last = num_tap_q - TAPW'(1);
   assign out_last = num_out_q - OUTW'(1);

   i8mac_seq_cnt #(.W(TAPW)) u_tap_cnt (
      .clk      (clk),
      .xreset   (xreset),
      .load     (tap_load),
      .load_val ('0),
      .inc      (tap_inc),
      .term_val (tap_last),
      .cnt      (tap_idx),
      .term     (tap_term)
   );

   i8mac_seq_cnt #(.W(OUTW)) u_out_cnt (
      .clk      (clk),
      .xreset   (xreset),
      .load     (out_load),
      .load_val ('0),
      .inc      (out_inc),
      .term_val (out_last),
      .cnt      (out_idx),
      .term     (out_term)
   );

   // Drain watchdog: counts cycles spent waiting for the MAC result.
   i8mac_seq_cnt #(.W(WDW)) u_wdog_cnt (
      .clk      (clk),
      .xreset   (xreset),
      .load     (wd_load),
      .load_val ('0),
      .inc      (wd_inc),
      .term_val (WDW'(DRNMAX)),
      .cnt      (wdog),
      .term     (wd_term)
   );

   // State register.
   always_ff @(posedge clk or posedge xreset) begin
      if (xreset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Latch the run counts when a start is accepted.
   always_ff @(posedge clk or posedge xreset) begin
      if (xreset) begin
         num_tap_q <= '0;
         num_out_q <= '0;
      end else if (accept) begin
         num_tap_q <= num_tap;
         num_out_q <= num_out;
      end
   end

   // Sticky drain-timeout flag; only the next accepted start clears it.
   always_ff @(posedge clk or posedge xreset) begin
      if (xreset) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= 1'b0;
      end else if (err_set) begin
         err_q <= 1'b1;
      end
   end

   // Next-state and counter control; abort overrides everything else.
   always_comb begin
      // NOTE: every signal gets its default first so no path through the case can infer a latch.
      state_nx = state;
      accept   = 1'b0;
      err_set  = 1'b0;
      tap_load = 1'b0;
      tap_inc  = 1'b0;
      out_load = 1'b0;
      out_inc  = 1'b0;
      wd_load  = 1'b0;
      wd_inc   = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               accept = 1'b1;
               // An empty run issues no MAC traffic at all.
               if (num_tap == '0 || num_out == '0) begin
                  state_nx = ST_DONE;
               end else begin
                  state_nx = ST_CLEAR;
               end
            end
         end

         ST_CLEAR: begin
            // Hold the tap index at 0 so ACC always begins at the first tap.
            tap_load = 1'b1;
            if (rdy) begin
               state_nx = ST_ACC;
            end
         end

         ST_ACC: begin
            // The MAC only samples aen on rdy cycles, so only those advance the tap.
            if (rdy) begin
               if (tap_term) begin
                  state_nx = ST_BIAS;
               end else begin
                  tap_inc = 1'b1;
               end
            end
         end

         ST_BIAS: begin
            // Arm the watchdog so DRAIN starts counting from 0.
            wd_load = 1'b1;
            if (rdy) begin
               state_nx = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            // A timeout is handled exactly like a result, minus res_valid.
            if (mac_acvalid || wd_term) begin
               err_set = !mac_acvalid;
               if (out_term) begin
                  state_nx = ST_DONE;
               end else begin
                  out_inc  = 1'b1;
                  state_nx = ST_CLEAR;
               end
            end else begin
               wd_inc = 1'b1;
            end
         end

         ST_DONE: begin
            tap_load = 1'b1;
            out_load = 1'b1;
            state_nx = ST_IDLE;
         end

         default: begin
            state_nx = ST_IDLE;
         end
      endcase

      // Abort drops straight to IDLE with zeroed indices; a dirty MAC is
      // cleaned up by the CLEAR of the next run.
      if (abort) begin
         state_nx = ST_IDLE;
         accept   = 1'b0;
         err_set  = 1'b0;
         tap_inc  = 1'b0;
         out_inc  = 1'b0;
         wd_inc   = 1'b0;
         tap_load = 1'b1;
         out_load = 1'b1;
         wd_load  = 1'b1;
      end
   end

   // Outputs are pure functions of state, so they hold whenever rdy stalls the state.
   assign acl       = (state == ST_CLEAR);
   assign aen       = (state == ST_ACC);
   assign ivalid    = (state == ST_ACC) && tap_ok;
   assign res_valid = (state == ST_DRAIN) && mac_acvalid;
   assign res_idx   = out_idx;
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);
   assign err       = err_q;

endmodule

// File: tb/tb_i8mac_seq.sv
// Bench for i8mac_seq: a behavioural i8mac stand-in plus a reference model
// that predicts each output point's accumulator value from the tap data.
module tb_i8mac_seq;
   import i8mac_seq_pkg::*;

   localparam int TAPW   = TAPW_DEF;
   localparam int OUTW   = OUTW_DEF;
   localparam int DRNMAX = DRNMAX_DEF;
   localparam int BUDGET = 3000;

   logic            clk = 1'b0;
   logic            xreset;
   logic            start;
   logic            abort;
   logic [TAPW-1:0] num_tap;
   logic [OUTW-1:0] num_out;
   logic            rdy = 1'b0;
   logic            tap_ok = 1'b0;
   logic            mac_acvalid = 1'b0;
   logic            acl;
   logic            aen;
   logic            ivalid;
   logic [TAPW-1:0] tap_idx;
   logic [OUTW-1:0] out_idx;
   logic            res_valid;
   logic [OUTW-1:0] res_idx;
   logic            busy;
   logic            done;
   logic            err;

   i8mac_seq dut (
      .clk         (clk),
      .xreset      (xreset),
      .start       (start),
      .abort       (abort),
      .num_tap     (num_tap),
      .num_out     (num_out),
      .rdy         (rdy),
      .tap_ok      (tap_ok),
      .mac_acvalid (mac_acvalid),
      .acl         (acl),
      .aen         (aen),
      .ivalid      (ivalid),
      .tap_idx     (tap_idx),
      .out_idx     (out_idx),
      .res_valid   (res_valid),
      .res_idx     (res_idx),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int val;
   } exp_t;

   // Tap data per (output, tap), bias and padding mask for the current run.
   int         in_v  [0:7][0:7];
   int         fil_v [0:7][0:7];
   int         bias_v;
   logic [7:0] ok_mask;
   int         rdy_mode;
   bit         mac_kill;
   bit         hold_chk;

   int         n_checks = 0;
   int         n_errors = 0;
   int         n_res;
   int         n_done;
   int         acc_steps;
   int         max_tap;
   bit         saw_acl_aen;
   exp_t       exp_q[$];

   logic            aen_prev = 1'b0;
   logic            rdy_prev = 1'b0;
   logic [TAPW-1:0] tap_prev = '0;

   // i8mac stand-in: clear/accumulate on rdy cycles, bias step on the first
   // rdy cycle with acl=aen=0 after accumulating, result 3 cycles later.
   int   mac_acc;
   int   mac_res;
   int   mac_lat;
   int   accd;
   logic mac_armed;

   always @(posedge clk or posedge xreset) begin
      if (xreset) begin
         mac_acc     <= 0;
         mac_res     <= 0;
         mac_lat     <= 0;
         mac_armed   <= 1'b0;
         mac_acvalid <= 1'b0;
         accd        <= 0;
      end else begin
         mac_acvalid <= 1'b0;
         if (mac_lat != 0) begin
            mac_lat <= mac_lat - 1;
            if (mac_lat == 1 && !mac_kill) begin
               mac_acvalid <= 1'b1;
               accd        <= mac_res;
            end
         end
         if (rdy) begin
            if (acl) begin
               mac_acc   <= 0;
               mac_armed <= 1'b0;
            end else if (aen) begin
               if (ivalid)
                  mac_acc <= mac_acc + in_v[out_idx[2:0]][tap_idx[2:0]] * fil_v[out_idx[2:0]][tap_idx[2:0]];
               mac_armed <= 1'b1;
            end else if (mac_armed) begin
               mac_res   <= mac_acc + bias_v;
               mac_armed <= 1'b0;
               mac_lat   <= 3;
            end
         end
      end
   end

   // Count accumulate steps the MAC actually takes.
   always @(posedge clk) begin
      if (!xreset && aen && rdy) acc_steps++;
   end

   // Input drivers (rdy, tap_ok), stall-hold check and result scoreboard.
   always @(negedge clk) begin
      if (hold_chk && !xreset && aen_prev && !rdy_prev) begin
         n_checks++;
         if (aen !== 1'b1 || tap_idx !== tap_prev) begin
            n_errors++;
            $display("FAIL rdy_hold: aen=%0b tap_idx=%0d, required aen=1 tap_idx=%0d", aen, tap_idx, tap_prev);
         end
      end
      case (rdy_mode)
         0:       rdy = 1'b1;
         1:       rdy = ~rdy;
         default: rdy = 1'($urandom_range(1));
      endcase
      tap_ok   = ok_mask[tap_idx[2:0]];
      aen_prev = aen;
      tap_prev = tap_idx;
      rdy_prev = rdy;

      if (!xreset) begin
         if (done) n_done++;
         if (acl || aen) saw_acl_aen = 1'b1;
         if (aen && int'(tap_idx) > max_tap) max_tap = int'(tap_idx);
         if (res_valid) begin
            n_res++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL result_unexpected: res_idx=%0d accd=%0d, required no result", res_idx, accd);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (int'(res_idx) != e.idx || accd != e.val) begin
                  n_errors++;
                  $display("FAIL result: res_idx=%0d accd=%0d, required res_idx=%0d accd=%0d",
                           res_idx, accd, e.idx, e.val);
               end
            end
         end
      end
   end

   task automatic fill_const();
      for (int o = 0; o < 8; o++)
         for (int t = 0; t < 8; t++) begin
            in_v[o][t]  = 1;
            fil_v[o][t] = 2;
         end
      bias_v  = 10;
      ok_mask = 8'hff;
   endtask

   task automatic fill_rand();
      for (int o = 0; o < 8; o++)
         for (int t = 0; t < 8; t++) begin
            in_v[o][t]  = int'($urandom_range(255)) - 128;
            fil_v[o][t] = int'($urandom_range(255)) - 128;
         end
      bias_v  = int'($urandom_range(2000)) - 1000;
      ok_mask = 8'($urandom_range(255));
   endtask

   // Reference model: each point's result is the bias plus the sum of
   // in*fil over its non-padding taps.
   task automatic build_exp(input int nt, input int no);
      if (nt == 0 || no == 0) return;
      for (int o = 0; o < no; o++) begin
         exp_t e;
         e.idx = o;
         e.val = bias_v;
         for (int t = 0; t < nt; t++)
            if (ok_mask[t]) e.val += in_v[o][t] * fil_v[o][t];
         exp_q.push_back(e);
      end
   endtask

   task automatic start_run(input int nt, input int no);
      if (!mac_kill) build_exp(nt, no);
      n_res       = 0;
      n_done      = 0;
      acc_steps   = 0;
      max_tap     = 0;
      saw_acl_aen = 1'b0;
      num_tap     = TAPW'(nt);
      num_out     = OUTW'(no);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      while (done !== 1'b1 && k < BUDGET) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (done !== 1'b1) begin
         n_errors++;
         $display("FAIL %s_done_timeout: done=%0b after %0d cycles, required done=1", name, done, k);
      end
      @(negedge clk);
   endtask

   task automatic wait_aen(input string name);
      int k = 0;
      while (aen !== 1'b1 && k < BUDGET) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (aen !== 1'b1) begin
         n_errors++;
         $display("FAIL %s_aen_timeout: aen=%0b, required aen=1", name, aen);
      end
   endtask

   task automatic finish_run(input int nt, input int no, input string name);
      int want_res;
      want_res = mac_kill ? 0 : no;
      wait_done(name);
      n_checks++;
      if (n_done != 1) begin
         n_errors++;
         $display("FAIL %s_done_count: got %0d, required 1", name, n_done);
      end
      n_checks++;
      if (n_res != want_res) begin
         n_errors++;
         $display("FAIL %s_result_count: got %0d, required %0d", name, n_res, want_res);
      end
      n_checks++;
      if (acc_steps != nt * no) begin
         n_errors++;
         $display("FAIL %s_acc_steps: got %0d, required %0d", name, acc_steps, nt * no);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL %s_missing_results: %0d outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
      n_checks++;
      if (busy !== 1'b0 || tap_idx !== '0 || out_idx !== '0) begin
         n_errors++;
         $display("FAIL %s_idle_after: busy=%0b tap_idx=%0d out_idx=%0d, required 0/0/0", name, busy, tap_idx, out_idx);
      end
   endtask

   task automatic check_all_zero(input string name);
      n_checks++;
      if ({acl, aen, ivalid, res_valid, busy, done, err} !== 7'b0 ||
          tap_idx !== '0 || out_idx !== '0 || res_idx !== '0) begin
         n_errors++;
         $display("FAIL %s: acl=%0b aen=%0b ivalid=%0b res_valid=%0b busy=%0b done=%0b err=%0b tap=%0d out=%0d res_idx=%0d, required all 0",
                  name, acl, aen, ivalid, res_valid, busy, done, err, tap_idx, out_idx, res_idx);
      end
   endtask

   task automatic test_reset();
      xreset = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("reset_held");
      xreset = 1'b0;
      @(negedge clk);
      check_all_zero("reset_released");
   endtask

   task automatic test_basic();
      fill_const();
      rdy_mode = 0;
      start_run(3, 2);
      finish_run(3, 2, "basic");
   endtask

   task automatic test_rdy_toggle();
      fill_const();
      rdy_mode = 1;
      hold_chk = 1'b1;
      start_run(3, 2);
      finish_run(3, 2, "rdy_toggle");
      hold_chk = 1'b0;
      rdy_mode = 0;
   endtask

   task automatic test_padding();
      fill_const();
      ok_mask = 8'b1111_1011;
      start_run(4, 2);
      finish_run(4, 2, "padding");
      n_checks++;
      if (max_tap != 3) begin
         n_errors++;
         $display("FAIL padding_last_tap: max tap_idx=%0d, required 3", max_tap);
      end
   endtask

   task automatic test_zero();
      int cases [2][2] = '{'{3, 0}, '{0, 3}};
      for (int i = 0; i < 2; i++) begin
         start_run(cases[i][0], cases[i][1]);
         n_checks++;
         if (done !== 1'b1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL zero%0d_done_pulse: done=%0b busy=%0b, required 1/1", i, done, busy);
         end
         @(negedge clk);
         n_checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL zero%0d_back_idle: done=%0b busy=%0b, required 0/0", i, done, busy);
         end
         n_checks++;
         if (saw_acl_aen || n_done != 1) begin
            n_errors++;
            $display("FAIL zero%0d_no_mac: saw_acl_aen=%0b done_count=%0d, required 0/1", i, saw_acl_aen, n_done);
         end
      end
   endtask

   task automatic test_abort();
      int k = 0;
      fill_const();
      start_run(5, 2);
      while (!(aen === 1'b1 && tap_idx == TAPW'(1)) && k < BUDGET) begin
         @(negedge clk);
         k++;
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || aen !== 1'b0 || tap_idx !== '0 || out_idx !== '0) begin
         n_errors++;
         $display("FAIL abort_to_idle: busy=%0b done=%0b aen=%0b tap=%0d out=%0d, required all 0",
                  busy, done, aen, tap_idx, out_idx);
      end
      @(negedge clk);
      n_checks++;
      if (n_done != 0 || n_res != 0) begin
         n_errors++;
         $display("FAIL abort_no_done: done_count=%0d results=%0d, required 0/0", n_done, n_res);
      end
      exp_q.delete();
      start_run(2, 1);
      finish_run(2, 1, "after_abort");
   endtask

   task automatic test_watchdog();
      int g = 1;
      fill_const();
      mac_kill = 1'b1;
      start_run(2, 2);
      wait_aen("wdog");
      while (aen === 1'b1 && g < BUDGET) begin
         @(negedge clk);
         g++;
      end
      g = 1;
      forever begin
         @(negedge clk);
         if (acl === 1'b1 || g > 4 * DRNMAX) break;
         g++;
         if (g <= DRNMAX && err !== 1'b0) begin
            n_checks++;
            n_errors++;
            $display("FAIL wdog_err_early: err=%0b after %0d gap cycles, required 0", err, g);
         end
      end
      n_checks++;
      if (g < DRNMAX + 1 || g > DRNMAX + 2) begin
         n_errors++;
         $display("FAIL wdog_gap: %0d cycles between ACC and next CLEAR, required %0d..%0d", g, DRNMAX + 1, DRNMAX + 2);
      end
      n_checks++;
      if (err !== 1'b1) begin
         n_errors++;
         $display("FAIL wdog_err_set: err=%0b, required 1", err);
      end
      finish_run(2, 2, "wdog");
      n_checks++;
      if (err !== 1'b1) begin
         n_errors++;
         $display("FAIL wdog_err_sticky: err=%0b, required 1", err);
      end
      mac_kill = 1'b0;
      start_run(1, 1);
      n_checks++;
      if (err !== 1'b0) begin
         n_errors++;
         $display("FAIL wdog_err_clear: err=%0b, required 0", err);
      end
      finish_run(1, 1, "after_wdog");
   endtask

   task automatic test_busy_start();
      fill_rand();
      rdy_mode = 2;
      start_run(3, 2);
      repeat (4) @(negedge clk);
      num_tap = TAPW'(7);
      num_out = OUTW'(5);
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      finish_run(3, 2, "busy_start");
      rdy_mode = 0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         int nt;
         int no;
         fill_rand();
         rdy_mode = int'($urandom_range(2));
         nt = int'($urandom_range(8, 1));
         no = int'($urandom_range(4, 1));
         start_run(nt, no);
         finish_run(nt, no, "random");
      end
      rdy_mode = 0;
   endtask

   task automatic test_xreset();
      fill_const();
      start_run(6, 1);
      wait_aen("xreset");
      #2;
      xreset = 1'b1;
      #1;
      check_all_zero("xreset_mid_acc");
      @(negedge clk);
      xreset = 1'b0;
      exp_q.delete();
      start_run(2, 1);
      finish_run(2, 1, "after_xreset");
   endtask

   initial begin
      xreset   = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      num_tap  = '0;
      num_out  = '0;
      mac_kill = 1'b0;
      hold_chk = 1'b0;
      rdy_mode = 0;
      fill_const();

      test_reset();
      test_basic();
      test_rdy_toggle();
      test_padding();
      test_zero();
      test_abort();
      test_watchdog();
      test_busy_start();
      test_random();
      test_xreset();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: bench did not finish, required completion");
      $fatal(1, "global timeout");
   end

endmodule
